// File: rtl/ofdm_subcarrier_demapper.sv
// Splits FFT-shifted 64-bin OFDM symbols into a 48-carrier data stream and a
// 4-carrier pilot stream; null bins are dropped. Both outputs are registered.
module ofdm_subcarrier_demapper #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sof_i,
  input  logic [WIDTH-1:0] i_tdata,
  input  logic             i_tlast,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [WIDTH-1:0] d_tdata,
  output logic             d_tlast,
  output logic             d_tvalid,
  input  logic             d_tready,
  output logic [WIDTH-1:0] p_tdata,
  output logic             p_tlast,
  output logic             p_tvalid,
  input  logic             p_tready,
  output logic             align_err_o
);

  typedef enum logic [1:0] {
    CLS_NULL,
    CLS_DATA,
    CLS_PILOT
  } bin_class_e;

  logic [5:0] bin;
  logic [5:0] data_cnt;
  logic [1:0] pilot_cnt;
  logic       sof_q;
  logic       sof;
  logic       accept;
  bin_class_e bin_class;

  assign sof    = sof_i & ~sof_q;
  assign accept = i_tvalid & i_tready;

  // Guard bands sit at both ends of the shifted spectrum, DC at bin 32.
  always_comb begin
    // NOTE: default assignment first so no path leaves the variable unassigned (no latch).
    bin_class = CLS_DATA;
    if (bin <= 6'd5 || bin == 6'd32 || bin >= 6'd59)
      bin_class = CLS_NULL;
    else if (bin == 6'd11 || bin == 6'd25 || bin == 6'd39 || bin == 6'd53)
      bin_class = CLS_PILOT;
  end

  // Only the consumer that the current bin targets can stall the input.
  always_comb begin
    i_tready = 1'b0;
    if (!sof) begin
      unique case (bin_class)
        CLS_NULL:  i_tready = 1'b1;
        CLS_PILOT: i_tready = ~p_tvalid | p_tready;
        CLS_DATA:  i_tready = ~d_tvalid | d_tready;
        default:   i_tready = 1'b0;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sof_q       <= 1'b0;
      bin         <= '0;
      data_cnt    <= '0;
      pilot_cnt   <= '0;
      d_tdata     <= '0;
      d_tlast     <= 1'b0;
      d_tvalid    <= 1'b0;
      p_tdata     <= '0;
      p_tlast     <= 1'b0;
      p_tvalid    <= 1'b0;
      align_err_o <= 1'b0;
    end else begin
      sof_q <= sof_i;
      if (sof) begin
        bin         <= '0;
        data_cnt    <= '0;
        pilot_cnt   <= '0;
        d_tvalid    <= 1'b0;
        p_tvalid    <= 1'b0;
        align_err_o <= 1'b0;
      end else begin
        if (d_tvalid && d_tready) d_tvalid <= 1'b0;
        if (p_tvalid && p_tready) p_tvalid <= 1'b0;

        if (accept) begin
          unique case (bin_class)
            CLS_DATA: begin
              d_tdata  <= i_tdata;
              d_tlast  <= (data_cnt == 6'd47);
              d_tvalid <= 1'b1;
              data_cnt <= (data_cnt == 6'd47) ? 6'd0 : data_cnt + 6'd1;
            end
            CLS_PILOT: begin
              p_tdata   <= i_tdata;
              p_tlast   <= (pilot_cnt == 2'd3);
              p_tvalid  <= 1'b1;
              pilot_cnt <= pilot_cnt + 2'd1;
            end
            default: ;
          endcase

          // An early tlast realigns the carrier counters to the next symbol;
          // this must follow the loads above so the clear takes priority.
          if (i_tlast && bin != 6'd63) begin
            bin         <= '0;
            data_cnt    <= '0;
            pilot_cnt   <= '0;
            align_err_o <= 1'b1;
          end else if (!i_tlast && bin == 6'd63) begin
            bin         <= '0;
            align_err_o <= 1'b1;
          end else if (i_tlast) begin
            bin <= '0;
          end else begin
            bin <= bin + 6'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ofdm_subcarrier_demapper.sv
// Randomised scoreboard bench for ofdm_subcarrier_demapper: a symbol-level model
// predicts the data/pilot streams and a monitor compares every output handshake.
module tb_ofdm_subcarrier_demapper;
  localparam int W = 32;

  typedef struct packed {
    logic [W-1:0] data;
    logic         last;
  } beat_t;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         sof_i;
  logic [W-1:0] i_tdata;
  logic         i_tlast;
  logic         i_tvalid;
  logic         i_tready;
  logic [W-1:0] d_tdata;
  logic         d_tlast;
  logic         d_tvalid;
  logic         d_tready;
  logic [W-1:0] p_tdata;
  logic         p_tlast;
  logic         p_tvalid;
  logic         p_tready;
  logic         align_err_o;

  logic rnd_on = 1'b0;
  logic d_set, p_set, d_rnd, p_rnd;
  assign d_tready = rnd_on ? d_rnd : d_set;
  assign p_tready = rnd_on ? p_rnd : p_set;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int d_seen = 0;
  int p_seen = 0;

  beat_t dq[$];
  beat_t pq[$];
  int    m_pos, m_dcnt, m_pcnt;
  logic  m_err;

  ofdm_subcarrier_demapper #(.WIDTH(W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .sof_i(sof_i),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .d_tdata(d_tdata), .d_tlast(d_tlast), .d_tvalid(d_tvalid), .d_tready(d_tready),
    .p_tdata(p_tdata), .p_tlast(p_tlast), .p_tvalid(p_tvalid), .p_tready(p_tready),
    .align_err_o(align_err_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: bound expired (t=%0t)", name, $time);
  endtask

  // Spectrum map of an 802.11a-style symbol in FFT-shifted order.
  function automatic bit is_null(input int b);
    return (b < 6) || (b == 32) || (b > 58);
  endfunction

  function automatic bit is_pilot(input int b);
    int pilots[4] = '{11, 25, 39, 53};
    foreach (pilots[k]) if (pilots[k] == b) return 1'b1;
    return 1'b0;
  endfunction

  task automatic reset_model();
    m_pos  = 0;
    m_dcnt = 0;
    m_pcnt = 0;
    m_err  = 1'b0;
    dq.delete();
    pq.delete();
  endtask

  task automatic model_accept(input logic [W-1:0] data, input logic last);
    beat_t b;
    b.data = data;
    if (is_pilot(m_pos)) begin
      b.last = (m_pcnt == 3);
      pq.push_back(b);
      m_pcnt = (m_pcnt + 1) % 4;
    end else if (!is_null(m_pos)) begin
      b.last = (m_dcnt == 47);
      dq.push_back(b);
      m_dcnt = (m_dcnt + 1) % 48;
    end
    if (last && m_pos != 63) begin
      m_err  = 1'b1;
      m_dcnt = 0;
      m_pcnt = 0;
    end
    if (!last && m_pos == 63) m_err = 1'b1;
    m_pos = (last || m_pos == 63) ? 0 : m_pos + 1;
  endtask

  // Called right after a negedge; returns right after the negedge following acceptance.
  task automatic send_beat(input logic [W-1:0] data, input logic last);
    int waited = 0;
    i_tvalid = 1'b1;
    i_tdata  = data;
    i_tlast  = last;
    #1;
    while (!i_tready && waited < 300) begin
      @(negedge clk_i);
      #1;
      waited++;
    end
    if (!i_tready) fail("send_beat_ready");
    else model_accept(data, last);
    @(negedge clk_i);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic send_symbol(input int n, input int last_at, input bit rnd);
    for (int b = 0; b < n; b++) send_beat(rnd ? W'($urandom) : W'(b), b == last_at);
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((dq.size() != 0 || pq.size() != 0) && n < 2000) begin
      @(negedge clk_i);
      n++;
    end
    #3;
    check(name, dq.size() + pq.size(), 0);
    @(negedge clk_i);
  endtask

  initial begin
    forever begin
      @(negedge clk_i);
      d_rnd = 1'($urandom_range(0, 1));
      p_rnd = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: a handshake seen after the negedge completes at the next posedge.
  initial begin
    beat_t e;
    forever begin
      @(negedge clk_i);
      #2;
      if (rst_ni && !(sof_i && !dut.sof_q)) begin
        if (d_tvalid && d_tready) begin
          if (dq.size() == 0) begin
            checks++; errors++;
            $display("FAIL d_unexpected: got beat %0h expected none", d_tdata);
          end else begin
            e = dq.pop_front();
            check("d_tdata", d_tdata, e.data);
            check("d_tlast", d_tlast, e.last);
          end
          d_seen++;
        end
        if (p_tvalid && p_tready) begin
          if (pq.size() == 0) begin
            checks++; errors++;
            $display("FAIL p_unexpected: got beat %0h expected none", p_tdata);
          end else begin
            e = pq.pop_front();
            check("p_tdata", p_tdata, e.data);
            check("p_tlast", p_tlast, e.last);
          end
          p_seen++;
        end
      end
    end
  end

  initial begin
    int t0, d0, p0, waited;
    rst_ni = 1'b0; sof_i = 1'b0; i_tdata = '0; i_tlast = 1'b0; i_tvalid = 1'b0;
    d_set = 1'b1; p_set = 1'b1;
    reset_model();
    repeat (2) @(negedge clk_i);
    check("rst_d_tvalid", d_tvalid, 0);
    check("rst_p_tvalid", p_tvalid, 0);
    check("rst_d_tlast", d_tlast, 0);
    check("rst_p_tlast", p_tlast, 0);
    check("rst_d_tdata", d_tdata, 0);
    check("rst_p_tdata", p_tdata, 0);
    check("rst_align_err", align_err_o, 0);
    rst_ni = 1'b1;
    @(negedge clk_i);

    // Clean symbol, both consumers always ready.
    t0 = cyc; d0 = d_seen; p0 = p_seen;
    send_symbol(64, 63, 0);
    check("sym1_cycles", cyc - t0, 64);
    drain("sym1_drain");
    check("sym1_d_count", d_seen - d0, 48);
    check("sym1_p_count", p_seen - p0, 4);
    check("sym1_align_err", align_err_o, 0);

    // Pilot consumer stalled for 20 cycles after bin 11 is loaded.
    p_set = 1'b0; d0 = d_seen; p0 = p_seen;
    fork
      send_symbol(64, 63, 0);
      begin
        waited = 0;
        while (!p_tvalid && waited < 200) begin @(negedge clk_i); waited++; end
        if (!p_tvalid) fail("stall_wait_pvalid");
        repeat (20) @(negedge clk_i);
        #1;
        check("stall_i_tready", i_tready, 0);
        check("stall_p_tvalid", p_tvalid, 1);
        check("stall_p_tdata", p_tdata, 11);
        check("stall_i_tdata_bin", i_tdata, 25);
        @(negedge clk_i);
        p_set = 1'b1;
      end
    join
    drain("stall_drain");
    check("stall_d_count", d_seen - d0, 48);
    check("stall_p_count", p_seen - p0, 4);

    // Random backpressure on both outputs over 100 symbols of random data.
    d0 = d_seen; p0 = p_seen;
    rnd_on = 1'b1;
    for (int s = 0; s < 100; s++) send_symbol(64, 63, 1);
    @(negedge clk_i);
    rnd_on = 1'b0;
    drain("rand_drain");
    check("rand_d_count", d_seen - d0, 4800);
    check("rand_p_count", p_seen - p0, 400);
    check("rand_align_err", align_err_o, m_err);

    // Early tlast at bin 40 realigns to the next symbol.
    check("early_err_before", align_err_o, 0);
    send_symbol(41, 40, 0);
    check("early_err_after", align_err_o, 1);
    d0 = d_seen;
    send_symbol(64, 63, 0);
    drain("early_drain");
    check("early_err_sticky", align_err_o, 1);

    // Start-of-frame mid-symbol with a held data beat.
    send_symbol(30, 63, 0);
    d_set = 1'b0;
    i_tvalid = 1'b1; i_tdata = 30; sof_i = 1'b1;
    #1;
    check("sof_i_tready", i_tready, 0);
    check("sof_pre_d_tvalid", d_tvalid, 1);
    @(negedge clk_i);
    i_tvalid = 1'b0; sof_i = 1'b0;
    #1;
    check("sof_d_tvalid", d_tvalid, 0);
    check("sof_align_err", align_err_o, 0);
    reset_model();
    d_set = 1'b1;
    @(negedge clk_i);
    d0 = d_seen; p0 = p_seen;
    send_symbol(64, 63, 0);
    drain("sof_drain");
    check("sof_d_count", d_seen - d0, 48);
    check("sof_p_count", p_seen - p0, 4);
    check("sof_err_clean", align_err_o, 0);

    // Asynchronous reset mid-symbol.
    send_symbol(20, 63, 0);
    #1;
    check("arst_pre_d_tvalid", d_tvalid, 1);
    #2;
    rst_ni = 1'b0;
    #1;
    check("arst_d_tvalid", d_tvalid, 0);
    check("arst_d_tdata", d_tdata, 0);
    check("arst_d_tlast", d_tlast, 0);
    check("arst_p_tvalid", p_tvalid, 0);
    check("arst_p_tdata", p_tdata, 0);
    check("arst_p_tlast", p_tlast, 0);
    check("arst_align_err", align_err_o, 0);
    reset_model();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(negedge clk_i);
    t0 = cyc; d0 = d_seen; p0 = p_seen;
    send_symbol(64, 63, 0);
    check("arst_cycles", cyc - t0, 64);
    drain("arst_drain");
    check("arst_d_count", d_seen - d0, 48);
    check("arst_p_count", p_seen - p0, 4);
    check("arst_err_final", align_err_o, 0);

    $display("test done: total=%0d bad=%0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
